// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM encoding and index helper for the 4-requester
// round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ...
// modulo 4.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk the scan order backwards so the earliest candidate is the last write.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            cand = ptr + SEL_W'(j);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four burst requesters, with a
// valid/ready output and a per-grant beat cap that forces rotation.
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [WIDTH-1:0]   i0,
    input  logic [WIDTH-1:0]   i1,
    input  logic [WIDTH-1:0]   i2,
    input  logic [WIDTH-1:0]   i3,
    input  logic               ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sel0,
    output logic               sel1,
    output logic               y_valid,
    output logic [WIDTH-1:0]   y,
    output logic               busy
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0]   owner;
    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic [CNT_W-1:0]   beat_inc;
    logic               xfer;
    logic               release_now;

    assign owner    = sel_q;
    assign beat_inc = beat_cnt_q + CNT_W'(1);

    // On release the picker must already see the rotated pointer so the next
    // owner is granted on the same edge.
    assign pick_ptr = (state_q == GRANT) ? next_idx(owner) : ptr_q;

    rr_pick_4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        release_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    sel_d      = pick_idx;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                release_now = !req[owner]
                           || (xfer && (last[owner] || beat_inc == CNT_W'(MAX_HOLD)));
                if (release_now) begin
                    ptr_d      = next_idx(owner);
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        sel_d = pick_idx;
                        gnt_d = NUM_REQ'(1) << pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == GRANT);
        y_valid = busy && req[owner];
        xfer    = y_valid && ready;
    end

    always_comb begin
        unique case (sel_q)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            default: y = i3;
        endcase
    end

    assign gnt  = gnt_q;
    assign sel0 = sel_q[0];
    assign sel1 = sel_q[1];

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for mux_4_1_rr_arbiter: directed scenarios plus random traffic on two
// instances (MAX_HOLD=4 and MAX_HOLD=1) against an owner/pointer reference model.
module tb_mux_4_1_rr_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   last = '0;
    logic         ready = 1'b0;
    logic [W-1:0] din [4];

    logic [3:0]   gnt_o  [2];
    logic         sel0_o [2];
    logic         sel1_o [2];
    logic         yv_o   [2];
    logic [W-1:0] y_o    [2];
    logic         busy_o [2];

    int n_cmp = 0;
    int n_err = 0;

    int m_owner [2];
    int m_ptr   [2];
    int m_beats [2];
    int m_sel   [2];
    int hold    [2] = '{4, 1};

    always #5 clk = ~clk;

    mux_4_1_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]), .ready(ready),
        .gnt(gnt_o[0]), .sel0(sel0_o[0]), .sel1(sel1_o[0]),
        .y_valid(yv_o[0]), .y(y_o[0]), .busy(busy_o[0])
    );

    mux_4_1_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]), .ready(ready),
        .gnt(gnt_o[1]), .sel0(sel0_o[1]), .sel1(sel1_o[1]),
        .y_valid(yv_o[1]), .y(y_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++)
            if (r[(p + j) % 4]) return (p + j) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1; m_ptr[u] = 0; m_beats[u] = 0; m_sel[u] = 0;
        end
    endtask

    task automatic compare(input int u);
        logic [3:0] eg;
        logic       ev;
        eg = '0;
        ev = 1'b0;
        if (m_owner[u] >= 0) begin
            eg[m_owner[u]] = 1'b1;
            ev = req[m_owner[u]];
        end
        chk($sformatf("gnt%0d", u), 32'(gnt_o[u]), 32'(eg));
        chk($sformatf("sel%0d", u), 32'({sel1_o[u], sel0_o[u]}), 32'(m_sel[u]));
        chk($sformatf("busy%0d", u), 32'(busy_o[u]), 32'(m_owner[u] >= 0));
        chk($sformatf("yv%0d", u), 32'(yv_o[u]), 32'(ev));
        chk($sformatf("y%0d", u), 32'(y_o[u]), 32'(din[m_sel[u]]));
    endtask

    task automatic advance(input int u);
        int  o, k;
        bit  xfer;
        o = m_owner[u];
        if (o < 0) begin
            k = pick(req, m_ptr[u]);
            if (k >= 0) begin
                m_owner[u] = k; m_sel[u] = k; m_beats[u] = 0;
            end
        end else begin
            xfer = req[o] && ready;
            if (xfer) m_beats[u]++;
            if ((xfer && (last[o] || m_beats[u] == hold[u])) || !req[o]) begin
                m_ptr[u] = (o + 1) % 4;
                k = pick(req, m_ptr[u]);
                if (k >= 0) begin
                    m_owner[u] = k; m_sel[u] = k;
                end else begin
                    m_owner[u] = -1;
                end
                m_beats[u] = 0;
            end
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        #1;
        for (int u = 0; u < 2; u++) begin
            compare(u);
            advance(u);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_gnt", 32'(gnt_o[u]), 32'h0);
            chk("rst_sel", 32'({sel1_o[u], sel0_o[u]}), 32'h0);
            chk("rst_yv", 32'(yv_o[u]), 32'h0);
            chk("rst_busy", 32'(busy_o[u]), 32'h0);
            chk("rst_y", 32'(y_o[u]), 32'(din[0]));
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] t2_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        for (int k = 0; k < 4; k++) din[k] = 8'(8'h10 + k);
        model_reset();
        @(negedge clk);
        apply_reset();

        // 1: single burst on requester 0
        din[0] = 8'hA5; req = 4'b0001; last = '0; ready = 1'b1;
        step();
        chk("t1_gnt", 32'(gnt_o[0]), 32'h1);
        for (int b = 0; b < 3; b++) begin
            last = (b == 2) ? 4'b0001 : 4'b0000;
            chk("t1_yv", 32'(yv_o[0]), 32'h1);
            chk("t1_y", 32'(y_o[0]), 32'hA5);
            step();
        end
        req = '0; last = '0;
        step();
        chk("t1_idle_gnt", 32'(gnt_o[0]), 32'h0);
        chk("t1_idle_busy", 32'(busy_o[0]), 32'h0);
        req = 4'b0011;
        step();
        chk("t1_ptr1", 32'(gnt_o[0]), 32'b0010);

        // 2: round-robin with single-beat bursts
        apply_reset();
        req = 4'b1111; last = 4'b1111; ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_gnt", 32'(gnt_o[0]), 32'(t2_gnt[i]));
            chk("t2_sel", 32'({sel1_o[0], sel0_o[0]}), 32'(i % 4));
            step();
        end

        // 3: forced rotation at MAX_HOLD=4
        apply_reset();
        req = 4'b0101; last = '0; ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin chk("t3_g0", 32'(gnt_o[0]), 32'b0001); step(); end
        for (int i = 0; i < 4; i++) begin chk("t3_g2", 32'(gnt_o[0]), 32'b0100); step(); end
        chk("t3_back", 32'(gnt_o[0]), 32'b0001);

        // 4: backpressure on owner 2
        apply_reset();
        din[2] = 8'h3C; req = 4'b0100; last = '0; ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_y", 32'(y_o[0]), 32'h3C);
            chk("t4_yv", 32'(yv_o[0]), 32'h1);
            chk("t4_gnt", 32'(gnt_o[0]), 32'b0100);
            step();
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // 5: abandon, idle, wrap-around scan from ptr=2
        apply_reset();
        req = 4'b0010; last = '0; ready = 1'b1;
        step();
        step();
        req = '0;
        #1;
        chk("t5_yv", 32'(yv_o[0]), 32'h0);
        step();
        chk("t5_gnt", 32'(gnt_o[0]), 32'h0);
        chk("t5_busy", 32'(busy_o[0]), 32'h0);
        req = 4'b0011;
        step();
        chk("t5_wrap", 32'(gnt_o[0]), 32'b0001);

        // 6: asynchronous reset in the middle of owner 3's burst
        apply_reset();
        req = 4'b1000; last = '0; ready = 1'b1;
        step();
        step();
        #2;
        apply_reset();
        req = 4'b1000;
        step();
        chk("t6_gnt", 32'(gnt_o[0]), 32'b1000);
        chk("t6_sel", 32'({sel1_o[0], sel0_o[0]}), 32'd3);

        // Random traffic with sticky requests
        apply_reset();
        req = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
                last[k] = ($urandom_range(0, 3) == 0);
                din[k]  = 8'($urandom);
            end
            ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 mux datapath among four requesters. Each requester presents a burst of data words. The block grants one requester at a time and drives the mux selects sel0/sel1. It forwards the selected word to a single downstream consumer using a valid/ready handshake, rotates priority after every burst, and caps how long any one requester can hold the mux.

Parameters:
WIDTH, 8, data width of each mux input and of the output word
MAX_HOLD, 4, maximum accepted beats per grant before forced rotation (must be >= 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  4  request from requester k (bit k)
last  input  4  bit k marks requester k's current word as end of burst
i0  input  WIDTH  data word, requester 0
i1  input  WIDTH  data word, requester 1
i2  input  WIDTH  data word, requester 2
i3  input  WIDTH  data word, requester 3
ready  input  1  downstream accepts y this cycle
gnt  output  4  one-hot grant (registered)
sel0  output  1  mux select LSB (registered)
sel1  output  1  mux select MSB (registered)
y_valid  output  1  y holds a valid word
y  output  WIDTH  selected word; index {sel1,sel0}
busy  output  1  high while state is GRANT

Behaviour:
- Interface (decided): one clock, clk; rst is asynchronous and active-high.
- Reset values:
  - gnt=4'b0000, sel1/sel0=0/0, y_valid=0, busy=0.
  - Internal: state=IDLE, ptr=0, beat_cnt=0.
  - y follows i0 while in reset.
  - Asserting rst mid-burst clears all state immediately and drops the burst; there is no resume.
- Mux: y = i[{sel1,sel0}]. This path is combinational from the registered selects.
- Transfer occurs when y_valid && ready.
- y_valid = busy && req[owner], where owner = {sel1,sel0}.
- Picker: starting at index ptr and scanning ptr, ptr+1, ... mod 4, select the first k with req[k]=1.
- FSM:
  - IDLE:
    - If req==0: stay in IDLE.
    - Else: on the next edge load gnt/sel with the winner, clear beat_cnt, and go to GRANT.
    - Latency: req rising at edge n gives gnt at edge n+1, and the first possible transfer is in cycle n+1.
  - GRANT:
    - On each transfer, beat_cnt increments. beat_cnt width is clog2(MAX_HOLD)+1.
    - Release occurs if any of these holds:
      - (a) transfer && last[owner];
      - (b) transfer && beat_cnt+1 == MAX_HOLD;
      - (c) req[owner]==0 (abandon; no transfer that cycle).
    - On release: ptr <= owner+1 mod 4, and the picker reruns using this new ptr.
      - If a winner exists: GRANT to the winner at the same edge (back-to-back, no bubble). beat_cnt is cleared. The former owner may win again only if no other req is set.
      - If no winner: go to IDLE with gnt=0, sel unchanged, busy=0.
- ready low: y, sel and beat_cnt hold. Data and selection are stable until accepted.
- last[k] with req[k]=0, or last on a non-owner, is ignored.
- Changes to req by non-owners during GRANT have no effect until release.
- MAX_HOLD=1: every accepted beat releases.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - function next_idx(idx) = idx+1 mod 4.
- Sub-module rr_pick_4: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once.
- The datapath y may be built as WIDTH bit-slices of the existing mux_4_1 cell, driven by sel0/sel1.

Test Plan:
1. Reset and single burst:
   - Stimulus: rst high then low; req=0001, i0=8'hA5, ready=1, last[0] on 3rd beat.
   - Required: gnt=0001 one cycle after req; y_valid with y=A5 for 3 cycles; then gnt=0000, busy=0, ptr=1.
2. Round-robin:
   - Stimulus: req=1111 constant, last on every beat, ready=1.
   - Required: gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; {sel1,sel0} = 00,01,10,11,00.
3. Forced rotation:
   - Stimulus: MAX_HOLD=4, req=0101, last never asserted.
   - Required: requester 0 gets exactly 4 beats; gnt moves to 0100 at the next edge; requester 2 gets 4 beats; gnt returns to 0001.
4. Backpressure:
   - Stimulus: owner 2, i2=8'h3C; ready low for 5 cycles, then high.
   - Required: y=3C, y_valid=1 and gnt=0100 held throughout; beat_cnt unchanged until ready=1.
5. Abandon and idle:
   - Stimulus: owner 1 drops req mid-burst; req=0000.
   - Required: y_valid=0 the same cycle; next edge state IDLE, gnt=0000, ptr=2. A later req=0011 is granted to 0001, because the scan starts at 2 and wraps.
6. Reset mid-burst:
   - Stimulus: rst asserted asynchronously between edges during owner 3's burst.
   - Required: gnt=0000, sel=00, y_valid=0, busy=0 immediately. After release, a new req=1000 is granted after one cycle with ptr=0.
